// File: rtl/nv_pipe_skid_rx.sv
// Receive-side 2-entry skid buffer: registers data, valid and ready for a valid/ready link,
// and raises a sticky flag when upstream changes payload or drops valid while stalled.
module nv_pipe_skid_rx #(
   parameter int unsigned DW = 32
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rstn,
   input  logic          in_pvld,
   output logic          in_prdy,
   input  logic [DW-1:0] in_pd,
   output logic          out_pvld,
   input  logic          out_prdy,
   output logic [DW-1:0] out_pd,
   output logic [1:0]    occ,
   input  logic          err_clr,
   output logic          err_proto
);

   logic          main_vld_q, main_vld_d;
   logic          skid_vld_q, skid_vld_d;
   logic [DW-1:0] main_pd_q, main_pd_d;
   logic [DW-1:0] skid_pd_q, skid_pd_d;
   logic          stall_q, stall_d;
   logic [DW-1:0] stall_pd_q;
   logic          err_q, err_d;
   logic          accept, pop, violation;

   // Ready depends only on the skid entry, so out_prdy never reaches in_prdy combinationally.
   assign in_prdy   = ~skid_vld_q;
   assign out_pvld  = main_vld_q;
   assign out_pd    = main_pd_q;
   assign occ       = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
   assign err_proto = err_q;

   assign accept = in_pvld & in_prdy;
   assign pop    = main_vld_q & out_prdy;

   always_comb begin
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_pd_d  = main_pd_q;
      skid_pd_d  = skid_pd_q;
      unique case ({main_vld_q, skid_vld_q})
         2'b00: begin
            if (accept) begin
               main_vld_d = 1'b1;
               main_pd_d  = in_pd;
            end
         end
         2'b10: begin
            if (accept && pop) begin
               main_pd_d = in_pd;
            end else if (accept) begin
               skid_vld_d = 1'b1;
               skid_pd_d  = in_pd;
            end else if (pop) begin
               main_vld_d = 1'b0;
            end
         end
         2'b11: begin
            if (pop) begin
               main_pd_d  = skid_pd_q;
               skid_vld_d = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   // A stalled beat must be held unchanged with valid kept high; a new violation beats a clear.
   assign violation = stall_q & (~in_pvld | (in_pd != stall_pd_q));
   assign stall_d   = in_pvld & ~in_prdy;
   assign err_d     = violation | (err_q & ~err_clr);

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         main_pd_q  <= '0;
         skid_pd_q  <= '0;
         stall_q    <= 1'b0;
         stall_pd_q <= '0;
         err_q      <= 1'b0;
      end else begin
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         main_pd_q  <= main_pd_d;
         skid_pd_q  <= skid_pd_d;
         stall_q    <= stall_d;
         stall_pd_q <= in_pd;
         err_q      <= err_d;
      end
   end

`ifdef NV_PIPE_SKID_ASSERT
   skid_without_main: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
      !(skid_vld_q && !main_vld_q));
`endif

endmodule

// File: tb/tb_nv_pipe_skid_rx.sv
// Directed and constrained-random bench for nv_pipe_skid_rx against a queue-based reference.
module tb_nv_pipe_skid_rx;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_pvld, in_prdy, out_pvld, out_prdy, err_clr, err_proto;
   logic [31:0] in_pd, out_pd;
   logic [1:0]  occ;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mq[$];
   logic        m_stall, m_err;
   logic [31:0] m_stall_pd;
   int          n_pop;
   logic [31:0] last_pop;
   int          max_occ;

   always #5 clk = ~clk;

   nv_pipe_skid_rx #(.DW(32)) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .in_pvld        (in_pvld),
      .in_prdy        (in_prdy),
      .in_pd          (in_pd),
      .out_pvld       (out_pvld),
      .out_prdy       (out_prdy),
      .out_pd         (out_pd),
      .occ            (occ),
      .err_clr        (err_clr),
      .err_proto      (err_proto)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs against the model, advance the model.
   task automatic cycle(input logic pv, input logic [31:0] pd, input logic op, input logic clr);
      logic m_prdy, acc, pop, viol;
      in_pvld  = pv;
      in_pd    = pd;
      out_prdy = op;
      err_clr  = clr;
      m_prdy   = (mq.size() < 2);
      if (mq.size() > max_occ) max_occ = mq.size();
      chk("occ", 32'(occ), 32'(mq.size()));
      chk("in_prdy", 32'(in_prdy), 32'(m_prdy));
      chk("out_pvld", 32'(out_pvld), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("out_pd", out_pd, mq[0]);
      chk("err_proto", 32'(err_proto), 32'(m_err));
      acc  = pv & m_prdy;
      pop  = (mq.size() > 0) & op;
      viol = m_stall & (~pv | (pd != m_stall_pd));
      @(posedge clk);
      if (pop) begin
         last_pop = mq.pop_front();
         n_pop++;
      end
      if (acc) mq.push_back(pd);
      m_err      = viol | (m_err & ~clr);
      m_stall    = pv & ~m_prdy;
      m_stall_pd = pd;
      #1;
   endtask

   task automatic finish_reset();
      mq.delete();
      m_stall    = 1'b0;
      m_stall_pd = '0;
      m_err      = 1'b0;
      in_pvld    = 1'b0;
      in_pd      = '0;
      out_prdy   = 1'b0;
      err_clr    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      logic pv, op;
      rstn = 1'b0;
      finish_reset();
      rstn = 1'b0;
      #1;
      chk("rst_out_pvld", 32'(out_pvld), 32'd0);
      chk("rst_in_prdy", 32'(in_prdy), 32'd1);
      chk("rst_out_pd", out_pd, 32'd0);
      finish_reset();

      // Streaming at full rate.
      n_pop = 0;
      for (int i = 0; i < 100; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("stream_pops", 32'(n_pop), 32'd100);
      chk("stream_last", last_pop, 32'd99);

      // Backpressure from cycle 5 through 9; upstream holds the beat while stalled.
      n_pop = 0; n = 0; max_occ = 0;
      for (int c = 0; c < 40; c++) begin
         pv = (n < 20);
         op = !(c >= 5 && c <= 9);
         if (c == 7) chk("bp_in_prdy_low", 32'(in_prdy), 32'd0);
         if (pv && mq.size() < 2) begin
            cycle(pv, 32'(n), op, 1'b0);
            n++;
         end else begin
            cycle(pv, 32'(n), op, 1'b0);
         end
      end
      chk("bp_max_occ", 32'(max_occ), 32'd2);
      chk("bp_pops", 32'(n_pop), 32'd20);
      chk("bp_last", last_pop, 32'd19);

      // Drain from full.
      cycle(1'b1, 32'h100, 1'b0, 1'b0);
      cycle(1'b1, 32'h101, 1'b0, 1'b0);
      chk("drain_full", 32'(occ), 32'd2);
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("drain_one", 32'(occ), 32'd1);
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("drain_empty", 32'(occ), 32'd0);
      chk("drain_in_prdy", 32'(in_prdy), 32'd1);
      chk("drain_last", last_pop, 32'h101);

      // Protocol violation while stalled at full.
      cycle(1'b1, 32'h1, 1'b0, 1'b0);
      cycle(1'b1, 32'h2, 1'b0, 1'b0);
      cycle(1'b1, 32'hA5, 1'b0, 1'b0);
      cycle(1'b1, 32'h5A, 1'b0, 1'b1);
      chk("viol_set_wins", 32'(err_proto), 32'd1);
      cycle(1'b1, 32'h5A, 1'b0, 1'b0);
      cycle(1'b1, 32'h5A, 1'b0, 1'b1);
      chk("viol_clr", 32'(err_proto), 32'd0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk("viol_drop", 32'(err_proto), 32'd1);
      chk("viol_occ", 32'(occ), 32'd2);

      // Asynchronous reset mid-stream with both entries full and the error flag set.
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_out_pvld", 32'(out_pvld), 32'd0);
      chk("mid_rst_in_prdy", 32'(in_prdy), 32'd1);
      chk("mid_rst_occ", 32'(occ), 32'd0);
      chk("mid_rst_err", 32'(err_proto), 32'd0);
      chk("mid_rst_out_pd", out_pd, 32'd0);
      finish_reset();

      // Random valid/ready traffic from a well-behaved upstream.
      n_pop = 0; n = 0;
      for (int c = 0; c < 10000; c++) begin
         if (m_stall) pv = 1'b1;
         else pv = 1'($urandom_range(0, 1));
         op = ($urandom_range(0, 3) != 0);
         if (pv && mq.size() < 2) begin
            cycle(pv, 32'(n), op, 1'b0);
            n++;
         end else begin
            cycle(pv, 32'(n), op, 1'b0);
         end
      end
      repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("rand_pops", 32'(n_pop), 32'(n));
      if (n > 0) chk("rand_last", last_pop, 32'(n - 1));
      chk("rand_err", 32'(err_proto), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
